// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch prefetch queue.
// Default widths/depths here are the values used when the top is not overridden.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W    = 32;
  localparam int unsigned FETCH_INST_W    = 32;
  localparam int unsigned FETCH_DEPTH     = 4;
  localparam int unsigned FETCH_MAX_OUTST = 2;

  localparam int unsigned CNT_W = $clog2(FETCH_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(FETCH_MAX_OUTST + 1);

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic FIFO with synchronous clear and occupancy count; head read is combinational.
// Latency: a push is visible at the head the following cycle.
// Backpressure: none internally; the owner must never push when full or pop when empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Explicit wrap keeps non-power-of-2 depths (tag FIFO sized by MAX_OUTST) correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// IF stage: sequential imem fetch into a prefetch queue, redirect flushes queued and in-flight work (FETCH_BYPASS_EN: empty-queue bypass).
// Latency: request fire N, response N+L, valid_o at N+L+1 (N+L when bypassing into an empty queue).
// Backpressure: ready_i low holds the queue; issue stops once queued + in-flight reaches DEPTH or in-flight reaches MAX_OUTST.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = FETCH_ADDR_W,
  parameter int unsigned INST_W    = FETCH_INST_W,
  parameter int unsigned DEPTH     = FETCH_DEPTH,
  parameter int unsigned MAX_OUTST = FETCH_MAX_OUTST,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [INST_W-1:0] imem_resp_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int unsigned QCNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned OUTST_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned TCNT_W  = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0]  pc_q, pc_n;
  logic [OUTST_W-1:0] inflight_q, inflight_n;
  logic [OUTST_W-1:0] drop_q, drop_n;

  logic              req_fire;
  logic              resp_keep;
  logic              bypass;
  logic              q_push, q_pop;
  entry_t            q_push_dat, q_head;
  logic [QCNT_W-1:0] q_count;
  logic [ADDR_W-1:0] tag_head;
  logic [TCNT_W-1:0] tag_cnt_unused;

  // Gated by reset_ni so no request is presented while reset is held.
  assign imem_req_valid_o = reset_ni && !redirect_i
                         && ((32'(q_count) + 32'(inflight_q)) < DEPTH)
                         && (32'(inflight_q) < MAX_OUTST);
  assign imem_addr_o = pc_q;
  assign req_fire    = imem_req_valid_o && imem_req_ready_i;

  assign resp_keep = imem_resp_valid_i && (drop_q == '0) && !redirect_i;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_keep && (q_count == '0) && ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign valid_o    = ((q_count != '0) || bypass) && !redirect_i;
  assign q_pop      = (q_count != '0) && !redirect_i && ready_i;
  assign q_push     = resp_keep && !bypass;
  assign q_push_dat = '{pc: tag_head, inst: imem_resp_data_i};
  assign pc_o       = bypass ? tag_head : q_head.pc;
  assign inst_o     = bypass ? imem_resp_data_i : q_head.inst;

  always_comb begin
    pc_n       = pc_q;
    drop_n     = drop_q;
    inflight_n = inflight_q + OUTST_W'(req_fire) - OUTST_W'(imem_resp_valid_i);
    if (redirect_i) begin
      pc_n   = redirect_pc_i;
      // Every response still owed belongs to the old stream, already-dropped ones included.
      drop_n = inflight_q - OUTST_W'(imem_resp_valid_i);
    end else begin
      if (req_fire) pc_n = pc_q + PC_INC;
      if (imem_resp_valid_i && (drop_q != '0)) drop_n = drop_q - OUTST_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_n;
      inflight_q <= inflight_n;
      drop_q     <= drop_n;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH),
    .CNT_W (QCNT_W)
  ) u_entry_q (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .clear_i    (redirect_i),
    .push_i     (q_push),
    .push_dat_i (q_push_dat),
    .pop_i      (q_pop),
    .pop_dat_o  (q_head),
    .count_o    (q_count)
  );

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTST),
    .CNT_W (TCNT_W)
  ) u_tag_q (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .clear_i    (redirect_i),
    .push_i     (req_fire),
    .push_dat_i (pc_q),
    .pop_i      (resp_keep),
    .pop_dat_o  (tag_head),
    .count_o    (tag_cnt_unused)
  );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order variable-latency memory plus a queue-level reference model.
// Directed phases with randomized knobs; outputs compared every cycle at negedge+1.
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH     = FETCH_DEPTH;
  localparam int unsigned MAX_OUTST = FETCH_MAX_OUTST;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] PC_INC    = 32'd4;

  logic        clk;
  logic        reset_ni;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  fetch_prefetch_queue dut (
    .clk_i             (clk),
    .reset_ni          (reset_ni),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_addr_o       (imem_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
    .inst_o            (inst_o),
    .pc_o              (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // stimulus knobs
  int rdy_pct      = 100;
  int mreq_pct     = 100;
  bit mreq_toggle  = 0;
  int lat_min      = 1;
  int lat_max      = 1;
  int redir_permil = 0;

  // memory: in-order responses, one per cycle at most
  logic [31:0] mem_addr[$];
  int          mem_due[$];

  // reference model
  logic [31:0]  m_pc;
  fetch_entry_t m_q[$];
  logic [31:0]  out_pc[$];
  bit           out_drop[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc);
    bit           resp_v, keep, byp, exp_v, exp_r, have_tag;
    logic [31:0]  tag_pc;
    fetch_entry_t e;
    int           due;

    @(negedge clk);
    cyc++;
    reset_ni          = !rst;
    ready_i           = ($urandom_range(99) < rdy_pct);
    imem_req_ready_i  = mreq_toggle ? cyc[0] : ($urandom_range(99) < mreq_pct);
    redirect_i        = !rst && (redir || ($urandom_range(999) < redir_permil));
    redirect_pc_i     = redir ? rpc : ($urandom & 32'hFFFF_FFFC);
    resp_v            = !rst && (mem_due.size() != 0) && (mem_due[0] <= cyc);
    imem_resp_valid_i = resp_v;
    imem_resp_data_i  = resp_v ? mem_word(mem_addr[0]) : $urandom;
    #1;

    if (rst) begin
      chk("reset_valid_o", {31'b0, valid_o}, 32'd0);
      chk("reset_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
      m_q.delete();
      out_pc.delete();
      out_drop.delete();
      mem_addr.delete();
      mem_due.delete();
      m_pc = RESET_PC;
      return;
    end

    have_tag = resp_v && (out_pc.size() != 0);
    keep     = have_tag && !out_drop[0] && !redirect_i;
`ifdef FETCH_BYPASS_EN
    byp = keep && (m_q.size() == 0) && ready_i;
`else
    byp = 1'b0;
`endif
    exp_v = !redirect_i && ((m_q.size() != 0) || byp);
    exp_r = !redirect_i && ((m_q.size() + out_pc.size()) < DEPTH) && (out_pc.size() < MAX_OUTST);

    chk("valid_o", {31'b0, valid_o}, {31'b0, exp_v});
    chk("imem_req_valid", {31'b0, imem_req_valid_o}, {31'b0, exp_r});
    if (exp_r) chk("imem_addr", imem_addr_o, m_pc);
    if (exp_v) begin
      if (byp) begin
        e.pc   = out_pc[0];
        e.inst = mem_word(out_pc[0]);
      end else begin
        e = m_q[0];
      end
      chk("pc_o", pc_o, e.pc);
      chk("inst_o", inst_o, e.inst);
    end

    // memory follows the DUT's actual handshake
    if (imem_req_valid_o && imem_req_ready_i) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (mem_due.size() != 0 && due <= mem_due[$]) due = mem_due[$] + 1;
      mem_addr.push_back(imem_addr_o);
      mem_due.push_back(due);
    end
    if (resp_v) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end

    tag_pc = '0;
    if (have_tag) begin
      tag_pc = out_pc.pop_front();
      void'(out_drop.pop_front());
    end

    if (redirect_i) begin
      m_q.delete();
      foreach (out_drop[i]) out_drop[i] = 1'b1;
      m_pc = redirect_pc_i;
    end else begin
      if (exp_v && ready_i && !byp) void'(m_q.pop_front());
      if (keep && !byp) begin
        e.pc   = tag_pc;
        e.inst = mem_word(tag_pc);
        m_q.push_back(e);
      end
      if (exp_r && imem_req_ready_i) begin
        out_pc.push_back(m_pc);
        out_drop.push_back(1'b0);
        m_pc = m_pc + PC_INC;
      end
    end
  endtask

  initial begin
    reset_ni          = 1'b0;
    redirect_i        = 1'b0;
    redirect_pc_i     = '0;
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = '0;
    ready_i           = 1'b0;
    m_pc              = RESET_PC;

    // reset, then streaming with L=1 and no stalls
    repeat (2) step(1, 0, '0);
    repeat (20) step(0, 0, '0);

    // decode stall fills the queue and stops issue, then drains in order
    rdy_pct = 0;
    repeat (10) step(0, 0, '0);
    rdy_pct = 100;
    repeat (10) step(0, 0, '0);

    // redirect with two requests outstanding
    lat_min = 3; lat_max = 3;
    repeat (6) step(0, 0, '0);
    step(0, 1, 32'h100);
    repeat (12) step(0, 0, '0);

    // redirect coinciding with a response, then back-to-back redirects
    lat_min = 1; lat_max = 1;
    repeat (5) step(0, 0, '0);
    step(0, 1, 32'h200);
    repeat (3) step(0, 0, '0);
    step(0, 1, 32'h300);
    step(0, 1, 32'h400);
    repeat (10) step(0, 0, '0);

    // memory accepting every other cycle, then address wrap
    mreq_toggle = 1;
    repeat (20) step(0, 0, '0);
    mreq_toggle = 0;
    step(0, 1, 32'hFFFF_FFF8);
    repeat (10) step(0, 0, '0);

    // randomized traffic
    rdy_pct = 70; mreq_pct = 70; lat_min = 1; lat_max = 4; redir_permil = 30;
    repeat (400) step(0, 0, '0);

    // reset mid-burst
    rdy_pct = 100; mreq_pct = 100; lat_min = 2; lat_max = 2; redir_permil = 0;
    repeat (8) step(0, 0, '0);
    repeat (2) step(1, 0, '0);
    repeat (12) step(0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
